// File: rtl/syscall_unit_if.sv
// Handshake bundle between the processor/console side and syscall_unit.
// The instruction request and the output record stream share one interface.
// master = processor + console sink side, slave = syscall_unit.
interface syscall_unit_if #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
);
  logic                   req_valid;
  logic [31:0]            instr_ID;
  logic [WIDTH-1:0]       rs;
  logic [WORDS*WIDTH-1:0] rt;
  logic                   stall;
  logic                   done;
  logic                   err;
  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_kind;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   halt;

  modport master (
    output req_valid, instr_ID, rs, rt, out_ready,
    input  stall, done, err, out_valid, out_kind, out_data, out_last, halt
  );

  modport slave (
    input  req_valid, instr_ID, rs, rt, out_ready,
    output stall, done, err, out_valid, out_kind, out_data, out_last, halt
  );
endinterface

// File: rtl/syscall_unit.sv
// syscall_unit: latches a syscall (instruction ID 26), stalls the processor
// while argument words are serialised into a record FIFO, and drains that
// FIFO to a console sink. exit halts only once all earlier output is gone.
// Optional macro SYSCALL_DISPLAY_EN: simulation-only printing of popped
// records and $finish on halt; without it the block is fully synthesizable.
module syscall_unit #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          reset,
  syscall_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EMIT, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [1:0]       kind;
    logic             last;
    logic [WIDTH-1:0] data;
  } rec_t;

  state_t                 state_q, state_d;
  logic [WORDS*WIDTH-1:0] rt_q, rt_d;
  logic [1:0]             kind_q, kind_d;
  logic [2:0]             cnt_q, cnt_d, n_q, n_d;
  logic                   done_q, done_d, err_q, err_d, halt_q, halt_d;
  // nop/error completes one cycle after acceptance; pend_q bridges that gap
  logic                   pend_q, pend_d, perr_q, perr_d;

  rec_t                   mem_q [DEPTH];
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [AW:0]            count_q, count_d;

  logic                   is_sys, accept, push, pop, ov;
  logic [WIDTH-1:0]       word;
  rec_t                   push_rec, head;

  logic                   dec_emit, dec_exit, dec_err;
  logic [1:0]             dec_kind;
  logic [2:0]             dec_n;

  assign is_sys = bus.req_valid && (bus.instr_ID == 32'd26);
  assign accept = is_sys && !done_q && !halt_q && !pend_q && (state_q == IDLE);

  // Decode the syscall code presented on rs into record kind / word count
  always_comb begin
    dec_emit = 1'b0;
    dec_exit = 1'b0;
    dec_err  = 1'b0;
    dec_kind = 2'd0;
    dec_n    = 3'd1;
    if (bus.rs == WIDTH'(1)) begin
      dec_emit = 1'b1;
    end else if (bus.rs == WIDTH'(8)) begin
      dec_emit = 1'b1;
      dec_kind = 2'd1;
    end else if (bus.rs == WIDTH'(2)) begin
      dec_exit = 1'b1;
    end else if (bus.rs == WIDTH'(3)) begin
      dec_emit = 1'b0;
    end else if (bus.rs >= WIDTH'(4) && bus.rs <= WIDTH'(7)) begin
      dec_n = {1'b0, bus.rs[1:0]} + 3'd1;
      if (int'(dec_n) > WORDS) begin
        dec_err = 1'b1;
      end else begin
        dec_emit = 1'b1;
        dec_kind = 2'd2;
      end
    end else begin
      dec_err = 1'b1;
    end
  end

  // Select argument word cnt_q for the record being pushed
  always_comb begin
    word = rt_q[WIDTH-1:0];
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == 3'(k)) word = rt_q[k*WIDTH +: WIDTH];
    end
  end

  assign push_rec = '{kind: kind_q, last: (cnt_q == n_q - 3'd1), data: word};

  // Next-state logic for the syscall FSM and the FIFO push request
  always_comb begin
    state_d = state_q;
    rt_d    = rt_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    halt_d  = halt_q;
    pend_d  = 1'b0;
    perr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          done_d = 1'b1;
          err_d  = perr_q;
        end else if (accept) begin
          rt_d = bus.rt;
          if (dec_emit) begin
            state_d = EMIT;
            cnt_d   = 3'd0;
            n_d     = dec_n;
            kind_d  = dec_kind;
          end else if (dec_exit) begin
            state_d = DRAIN;
          end else begin
            pend_d = 1'b1;
            perr_d = dec_err;
          end
        end
      end
      EMIT: begin
        // push is gated on the registered count only: a same-cycle pop at
        // full does not make room
        if (!count_q[AW]) begin
          push  = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n_q - 3'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (count_q == '0) begin
          done_d  = 1'b1;
          halt_d  = 1'b1;
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
  end

  // FSM and captured-syscall registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rt_q    <= '0;
      kind_q  <= 2'd0;
      cnt_q   <= 3'd0;
      n_q     <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      pend_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rt_q    <= rt_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
    end
  end

  assign ov      = (count_q != '0);
  assign pop     = ov && bus.out_ready;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy qualifies them
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= push_rec;
  end

  assign head = mem_q[rptr_q];

  assign bus.stall     = is_sys && !done_q && !halt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.halt      = halt_q;
  assign bus.out_valid = ov;
  assign bus.out_kind  = ov ? head.kind : 2'd0;
  assign bus.out_data  = ov ? head.data : '0;
  assign bus.out_last  = ov ? head.last : 1'b0;

`ifdef SYSCALL_DISPLAY_EN
  // Console model: print each popped record, end simulation on halt
  always @(posedge clk) begin
    if (!reset && pop) begin
      case (head.kind)
        2'd0:    $display("%d", $signed(head.data));
        2'd1:    $display("%d", head.data);
        default: $display("%s", head.data);
      endcase
    end
    if (!reset && state_q == DRAIN && state_d == HALTED) begin
      #5 $finish;
    end
  end
`else
  // Synthesizable build: halt is the only exit indication.
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: table of single syscalls (two DUT configurations),
// randomized syscalls against a queue-based reference model, and hand-written
// sequences for backpressure, mid-emit reset and ordered exit.
`timescale 1ns/1ps
module tb_syscall_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           req_valid;
  logic [31:0]    instr_id;
  logic [W-1:0]   rs;
  logic [4*W-1:0] rt;
  logic           out_ready;
  logic           use2;
  bit             rnd_rdy;

  syscall_unit_if #(.WIDTH(W), .WORDS(4)) bus();
  syscall_unit_if #(.WIDTH(W), .WORDS(2)) bus2();

  assign bus.req_valid  = req_valid && !use2;
  assign bus.instr_ID   = instr_id;
  assign bus.rs         = rs;
  assign bus.rt         = rt;
  assign bus.out_ready  = out_ready && !use2;
  assign bus2.req_valid = req_valid && use2;
  assign bus2.instr_ID  = instr_id;
  assign bus2.rs        = rs;
  assign bus2.rt        = rt[2*W-1:0];
  assign bus2.out_ready = out_ready && use2;

  syscall_unit #(.WIDTH(W), .WORDS(4), .DEPTH(8)) u1 (.clk(clk), .reset(reset), .bus(bus));
  syscall_unit #(.WIDTH(W), .WORDS(2), .DEPTH(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  logic         m_stall, m_done, m_err, m_ov, m_last, m_halt;
  logic [1:0]   m_kind;
  logic [W-1:0] m_data;
  assign m_stall = use2 ? bus2.stall     : bus.stall;
  assign m_done  = use2 ? bus2.done      : bus.done;
  assign m_err   = use2 ? bus2.err       : bus.err;
  assign m_ov    = use2 ? bus2.out_valid : bus.out_valid;
  assign m_last  = use2 ? bus2.out_last  : bus.out_last;
  assign m_halt  = use2 ? bus2.halt      : bus.halt;
  assign m_kind  = use2 ? bus2.out_kind  : bus.out_kind;
  assign m_data  = use2 ? bus2.out_data  : bus.out_data;

  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] data;
    logic         last;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference model: records a syscall code should produce, and its error flag
  function automatic bit model(input logic [W-1:0] code, input logic [4*W-1:0] r);
    int words;
    words = use2 ? 2 : 4;
    if (code == 1 || code == 8) begin
      exp_q.push_back('{(code == 8) ? 2'd1 : 2'd0, r[W-1:0], 1'b1});
      return 1'b0;
    end
    if (code == 2 || code == 3) return 1'b0;
    if (code >= 4 && code <= 7) begin
      int n;
      n = int'(code) - 3;
      if (n > words) return 1'b1;
      for (int k = 0; k < n; k++) exp_q.push_back('{2'd2, r[k*W +: W], (k == n-1)});
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // Sink monitor: collects popped records, checks head stability under backpressure
  logic prev_hold = 1'b0;
  rec_t prev_rec;
  always @(negedge clk) begin
    if (!reset && prev_hold)
      chk("hold_stable", {m_ov, m_kind, m_last, m_data},
          {1'b1, prev_rec.kind, prev_rec.last, prev_rec.data});
    if (!reset && m_ov && out_ready) got_q.push_back('{m_kind, m_data, m_last});
    prev_hold <= !reset && m_ov && !out_ready;
    prev_rec  <= '{m_kind, m_data, m_last};
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic present(input logic [W-1:0] code, input logic [4*W-1:0] r, output bit me);
    me        = model(code, r);
    req_valid = 1'b1;
    instr_id  = 32'd26;
    rs        = code;
    rt        = r;
  endtask

  // Hold the request until done; lat = n when done is high in the cycle after edge n
  task automatic wait_done(input int bound, output int lat, output bit e, output bit sok);
    lat = -1;
    e   = 1'b0;
    sok = 1'b1;
    for (int i = 0; i <= bound; i++) begin
      @(negedge clk);
      if (m_done) begin
        lat = i - 1;
        e   = m_err;
        sok = sok && !m_stall;
        break;
      end
      sok = sok && m_stall;
      tick();
    end
    if (lat < 0) $display("FAIL wait_done: no done within %0d cycles", bound);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [W-1:0]   code;
    logic [4*W-1:0] r;
    bit             e;
    int             nrec;
    int             lat;
    bit             u2;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit e, me, sok, ok;
    logic [W-1:0]   c;
    logic [4*W-1:0] r;

    reset = 1'b1; req_valid = 1'b0; instr_id = '0; rs = '0; rt = '0;
    out_ready = 1'b0; use2 = 1'b0; rnd_rdy = 1'b0;

    tv[0]  = '{32'd1, {96'd0, 32'hFFFF_FFFB}, 1'b0, 1, 1, 1'b0};
    tv[1]  = '{32'd7, {"MNOP", "IJKL", "EFGH", "ABCD"}, 1'b0, 4, 4, 1'b0};
    tv[2]  = '{32'd4, {96'd0, "WXYZ"}, 1'b0, 1, 1, 1'b0};
    tv[3]  = '{32'd5, {64'd0, "5678", "1234"}, 1'b0, 2, 2, 1'b0};
    tv[4]  = '{32'd6, {32'd0, "ghij", "cdef", "ab!?"}, 1'b0, 3, 3, 1'b0};
    tv[5]  = '{32'd8, {96'd0, 32'h8000_0000}, 1'b0, 1, 1, 1'b0};
    tv[6]  = '{32'd3, {4{32'hDEAD_BEEF}}, 1'b0, 0, 1, 1'b0};
    tv[7]  = '{32'd9, {4{32'h1111_2222}}, 1'b1, 0, 1, 1'b0};
    tv[8]  = '{32'd0, {4{32'h3333_4444}}, 1'b1, 0, 1, 1'b0};
    tv[9]  = '{32'h0000_0104, {4{32'h5555_6666}}, 1'b1, 0, 1, 1'b0};
    tv[10] = '{32'd6, {32'd0, "ghij", "cdef", "ab!?"}, 1'b1, 0, 1, 1'b1};
    tv[11] = '{32'd9, {4{32'h7777_8888}}, 1'b1, 0, 1, 1'b1};
    tv[12] = '{32'd3, {4{32'h9999_AAAA}}, 1'b0, 0, 1, 1'b1};
    tv[13] = '{32'd5, {64'd0, "WXYZ", "QRST"}, 1'b0, 2, 2, 1'b1};
    tv[14] = '{32'd7, {4{32'hBBBB_CCCC}}, 1'b1, 0, 1, 1'b1};

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {m_stall, m_done, m_err, m_ov, m_last, m_halt, m_kind, m_data}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Non-syscall instruction never stalls nor starts anything
    req_valid = 1'b1; instr_id = 32'd25; rs = 32'd1; rt = '1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      ok = ok && !m_stall && !m_done && !m_ov;
      tick();
    end
    chk("non_syscall_ignored", ok, 1);
    req_valid = 1'b0;
    tick();

    // Table-driven single syscalls, no backpressure
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      use2 = tv[i].u2;
      present(tv[i].code, tv[i].r, me);
      wait_done(200, lat, e, sok);
      chk($sformatf("tv%0d_err", i), e, tv[i].e);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("tv%0d_stall", i), sok, 1);
      tick(); tick();
      chk($sformatf("tv%0d_nrec", i), got_q.size(), tv[i].nrec);
      cmp_q($sformatf("tv%0d_rec", i));
    end
    use2 = 1'b0;
    tick();

    // Randomized syscalls with random sink readiness
    rnd_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      c = W'($urandom_range(0, 11));
      if (c == 11) c = $urandom;
      if (c == 2) c = 32'd3;
      r = {$urandom, $urandom, $urandom, $urandom};
      present(c, r, me);
      wait_done(300, lat, e, sok);
      chk($sformatf("rnd%0d_err", t), e, me);
      chk($sformatf("rnd%0d_done", t), (lat >= 0), 1);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    cmp_q("rnd_rec");

    // Backpressure: three 4-word strings into an 8-deep FIFO
    out_ready = 1'b0;
    present(32'd7, {"MNOP", "IJKL", "EFGH", "ABCD"}, me);
    wait_done(50, lat, e, sok);
    chk("bp1_lat", lat, 4);
    present(32'd7, {"mnop", "ijkl", "efgh", "abcd"}, me);
    wait_done(50, lat, e, sok);
    chk("bp2_lat", lat, 4);
    present(32'd7, {"3333", "2222", "1111", "0000"}, me);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok = ok && m_stall && !m_done && m_ov;
      tick();
    end
    chk("bp3_stalled_while_full", ok, 1);
    out_ready = 1'b1;
    wait_done(50, lat, e, sok);
    chk("bp3_done", (lat >= 0), 1);
    repeat (12) tick();
    chk("bp_nrec", got_q.size(), 12);
    cmp_q("bp_rec");

    // Reset in the middle of a 4-word emit, after two pushes
    out_ready = 1'b0;
    present(32'd7, {"MNOP", "IJKL", "EFGH", "ABCD"}, me);
    tick(); tick(); tick();
    reset = 1'b1;
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_state", {m_ov, m_stall, m_done, m_halt}, 4'b0000);
    tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    present(32'd1, {96'd0, 32'h0000_002A}, me);
    wait_done(50, lat, e, sok);
    chk("midrst_fresh_lat", lat, 1);
    chk("midrst_fresh_err", e, 0);
    tick(); tick();
    cmp_q("midrst_rec");

    // Ordered exit: halt only after the pending unsigned record leaves
    out_ready = 1'b0;
    present(32'd8, {96'd0, 32'hFEDC_BA98}, me);
    wait_done(50, lat, e, sok);
    chk("exit_u_lat", lat, 1);
    present(32'd2, '0, me);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok = ok && !m_halt && !m_done && m_stall && m_ov;
      tick();
    end
    chk("exit_waits_for_drain", ok, 1);
    out_ready = 1'b1;
    wait_done(50, lat, e, sok);
    chk("exit_done", (lat >= 0), 1);
    chk("exit_err", e, 0);
    chk("exit_rec_before_halt", got_q.size(), 1);
    @(negedge clk);
    chk("halt_set", m_halt, 1);
    tick();
    req_valid = 1'b1; instr_id = 32'd26; rs = 32'd1; rt = '1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok = ok && !m_stall && !m_done && !m_ov && m_halt;
      tick();
    end
    chk("halted_ignores", ok, 1);
    req_valid = 1'b0;
    cmp_q("exit_rec");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
